inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues sequential reads to instruction memory,
// captures responses into a small queue and presents the queue head to decode.
// Branch redirects reload the PC, flush the queue and drop any stale response.
// Optional: define INST_FETCH_PERF_EN to add issued-read and redirect counters.
module inst_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h3000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_fetch,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  output logic [15:0] PC,
  output logic        instrmem_rd,
  input  logic [15:0] instr_dout,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_instr,
  output logic [15:0] dec_npc
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 2;
  localparam logic [PW:0]   QFULL = (PW+1)'(QDEPTH);
  localparam logic [CW-1:0] QD_C  = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, RUN, REDIRECT} state_t;

  state_t        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [15:0]   issue_pc_q;
  logic          inflight_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   occ_q, occ_d;
  logic [15:0]   instr_mem_q [QDEPTH];
  logic [15:0]   npc_mem_q   [QDEPTH];

  logic          push;
  logic          pop;
  logic          full;
  logic [CW-1:0] credit;

  // A read slot is free when the queue plus the outstanding read leave room;
  // an entry leaving toward decode this cycle frees one slot immediately.
  assign dec_valid   = (occ_q != '0);
  assign pop         = dec_valid & dec_ready;
  assign full        = (occ_q == QFULL);
  assign credit      = QD_C - CW'(occ_q) - CW'(inflight_q) + CW'(pop);
  assign instrmem_rd = (state_q == RUN) && !br_taken && (credit != '0);
  // Responses landing in REDIRECT or alongside a redirect belong to the old path.
  assign push        = inflight_q && (state_q != REDIRECT) && !br_taken;
  assign PC          = pc_q;
  assign dec_instr   = dec_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign dec_npc     = dec_valid ? npc_mem_q[rd_ptr_q]   : '0;

  // Next-state for the FSM, PC and queue bookkeeping; redirect wins over all.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (br_taken) begin
      state_d  = REDIRECT;
      pc_d     = taddr;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      case (state_q)
        IDLE:     if (enable_fetch) state_d = RUN;
        RUN:      if (!enable_fetch) state_d = IDLE;
        REDIRECT: state_d = enable_fetch ? RUN : IDLE;
        default:  state_d = IDLE;
      endcase
      if (instrmem_rd) pc_d = pc_q + 16'd1;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   occ_d = occ_q + (PW+1)'(1);
        2'b01:   occ_d = occ_q - (PW+1)'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state: FSM, PC, queue pointers/occupancy and the inflight flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= instrmem_rd;
    end
  end

  // Remember the address of the read in flight so its npc can be formed on return.
  always_ff @(posedge clock) begin
    if (instrmem_rd) issue_pc_q <= pc_q;
  end

  // Queue storage: write the returning instruction and its npc at the tail.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= instr_dout;
      npc_mem_q[wr_ptr_q]   <= issue_pc_q + 16'd1;
    end
  end

  // Credit accounting must make a push into a full, non-draining queue impossible.
  queue_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && full && !pop));

`ifdef INST_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  // Free-running event counters for issued reads and redirects.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (instrmem_rd) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (br_taken)    flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: reference model plus decode-side scoreboard.
`timescale 1ns/1ps
module tb_inst_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h3000;
  localparam int          QDEPTH   = 2;
  localparam int S_IDLE = 0, S_RUN = 1, S_REDIR = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_fetch = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] taddr = 16'h0;
  logic [15:0] instr_dout = 16'h0;
  logic        dec_ready = 1'b0;
  logic [15:0] PC;
  logic        instrmem_rd;
  logic        dec_valid;
  logic [15:0] dec_instr;
  logic [15:0] dec_npc;
`ifdef INST_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  inst_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .enable_fetch(enable_fetch),
    .br_taken(br_taken),
    .taddr(taddr),
    .PC(PC),
    .instrmem_rd(instrmem_rd),
    .instr_dout(instr_dout),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .dec_instr(dec_instr),
    .dec_npc(dec_npc)
`ifdef INST_FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] npc;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];

  // Reference model state
  int          m_st = S_IDLE;
  logic [15:0] m_pc = RESET_PC;
  bit          m_infl = 1'b0;
  logic [15:0] m_infl_addr = 16'h0;
  int          m_fetch = 0;
  int          m_flush = 0;
  // Memory responder state (follows the DUT's actual reads)
  bit          mem_pend = 1'b0;
  logic [15:0] mem_addr = 16'h0;
  logic [15:0] mem_xor = 16'h0;
  int          dut_rd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive inputs, check control outputs against the model,
  // then advance the model across the rising edge.
  task automatic cycle(input bit en, input bit br, input logic [15:0] ta, input bit rdy);
    int          credit;
    bit          m_valid;
    bit          m_pop;
    bit          m_rd;
    logic [15:0] pc_old;
    @(negedge clock);
    enable_fetch = en;
    br_taken     = br;
    taddr        = ta;
    dec_ready    = rdy;
    instr_dout   = mem_pend ? (mem_addr ^ mem_xor) : 16'($urandom);
    #1;
    m_valid = (exp_q.size() != 0);
    m_pop   = m_valid && rdy;
    credit  = QDEPTH - exp_q.size() - int'(m_infl) + int'(m_pop);
    m_rd    = (m_st == S_RUN) && !br && (credit > 0);
    chk("instrmem_rd", instrmem_rd, m_rd);
    chk("PC", PC, m_pc);
    chk("dec_valid", dec_valid, m_valid);
    mem_pend = instrmem_rd;
    mem_addr = PC;
    if (instrmem_rd) dut_rd_cnt++;
    @(posedge clock);
    pc_old = m_pc;
    if (br) begin
      exp_q.delete();
      m_pc = ta;
      m_st = S_REDIR;
    end else begin
      if (m_infl && m_st != S_REDIR)
        exp_q.push_back('{instr: m_infl_addr ^ mem_xor, npc: m_infl_addr + 16'd1});
      if (m_rd) m_pc = m_pc + 16'd1;
      m_st = en ? S_RUN : S_IDLE;
    end
    m_infl      = m_rd;
    m_infl_addr = pc_old;
    m_fetch     += int'(m_rd);
    m_flush     += int'(br);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    #3;
    reset        = 1'b1;
    enable_fetch = 1'b0;
    br_taken     = 1'b0;
    #1;
    chk("rst dec_valid", dec_valid, 1'b0);
    chk("rst PC", PC, RESET_PC);
    chk("rst instrmem_rd", instrmem_rd, 1'b0);
    chk("rst dec_instr", dec_instr, 16'h0);
    chk("rst dec_npc", dec_npc, 16'h0);
`ifdef INST_FETCH_PERF_EN
    chk("rst perf_fetch_cnt", perf_fetch_cnt, 32'h0);
    chk("rst perf_flush_cnt", perf_flush_cnt, 32'h0);
`endif
    exp_q.delete();
    m_pc     = RESET_PC;
    m_st     = S_IDLE;
    m_infl   = 1'b0;
    mem_pend = 1'b0;
    m_fetch  = 0;
    m_flush  = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Decode-side monitor: pops the scoreboard on every accepted head and checks
  // that a stalled head does not change.
  initial begin
    ent_t        e;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_instr = 16'h0;
    logic [15:0] prev_npc = 16'h0;
    forever begin
      @(negedge clock);
      #2;
      if (prev_stall && dec_valid && !reset) begin
        chk("stall dec_instr", dec_instr, prev_instr);
        chk("stall dec_npc", dec_npc, prev_npc);
      end
      if (dec_valid && dec_ready && !reset) begin
        if (exp_q.size() == 0) begin
          chk("unexpected head", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("dec_instr", dec_instr, e.instr);
          chk("dec_npc", dec_npc, e.npc);
        end
      end
      prev_stall = dec_valid && !dec_ready && !reset;
      prev_instr = dec_instr;
      prev_npc   = dec_npc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit prev_br;
    bit br;
    logic [15:0] ta;

    // Reset, then straight-line fetch with data equal to address
    apply_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 16'h0, 1'b1);

    // Decode stalled: only QDEPTH reads may go out
    apply_reset();
    dut_rd_cnt = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    #1;
    chk("stall PC", PC, 16'h3002);
    chk("stall read count", dut_rd_cnt, 2);

    // Reset with a full queue, then fetch resumes from the reset PC
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'h0, 1'b1);

    // Redirect while a read is inflight
    cycle(1'b1, 1'b1, 16'h4000, 1'b1);
    #1;
    chk("redirect PC", PC, 16'h4000);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16'h0, 1'b1);

    // Redirect to the top of the address space to exercise PC wrap
    cycle(1'b1, 1'b1, 16'hFFFF, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16'h0, 1'b1);
`ifdef INST_FETCH_PERF_EN
    #1;
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'(m_fetch));
    chk("perf_flush_cnt", perf_flush_cnt, 32'(m_flush));
`endif

    // Randomized traffic with scrambled memory contents and one mid-run reset
    mem_xor = 16'hC3A5;
    prev_br = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        apply_reset();
        prev_br = 1'b0;
      end
      br = !prev_br && ($urandom_range(0, 15) == 0);
      ta = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      cycle($urandom_range(0, 7) != 0, br, ta, $urandom_range(0, 3) != 0);
      prev_br = br;
    end
`ifdef INST_FETCH_PERF_EN
    #1;
    chk("perf_fetch_cnt end", perf_fetch_cnt, 32'(m_fetch));
    chk("perf_flush_cnt end", perf_flush_cnt, 32'(m_flush));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
